seq_multiplier: RTL

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

---
 rtl/seq_multiplier.sv | 103 ++++++++++
 1 files changed

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier, unsigned or two's complement, one multiplier bit per cycle.
// Latency: out_valid rises exactly WIDTH cycles after the accepting edge; no early exit on zero.
// Backpressure: p and out_valid hold in DONE until out_ready; in_valid is ignored outside IDLE.
module seq_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state, state_nxt;
    logic [WIDTH-1:0]     mag_a, mag_b;
    logic                 neg;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   acc, acc_nxt;
    logic                 last;

    assign last = (cnt == CW'(WIDTH - 1));

    always_comb begin
        acc_nxt = acc;
        if (mag_b[cnt]) begin
            acc_nxt = acc + ({{WIDTH{1'b0}}, mag_a} << cnt);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = CALC;
            end
            CALC: begin
                if (last) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Magnitudes are WIDTH-bit unsigned, so the most negative operand maps to 2^(WIDTH-1) cleanly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mag_a <= '0;
            mag_b <= '0;
            neg   <= 1'b0;
            cnt   <= '0;
            acc   <= '0;
            p     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mag_a <= (signed_mode && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
                        mag_b <= (signed_mode && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
                        neg   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                        cnt   <= '0;
                        acc   <= '0;
                    end
                end
                CALC: begin
                    acc <= acc_nxt;
                    cnt <= cnt + CW'(1);
                    if (last) begin
                        p <= neg ? (~acc_nxt + (2*WIDTH)'(1)) : acc_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
